fs_shift_bank: RTL and testbench

//  Parametrised multi-channel bidirectional shift register bank with parallel load, hold,

---
 rtl/fs_shift_bank_if.sv | 29 ++
 rtl/fs_shift_bank.sv | 83 ++++++++
 tb/tb_fs_shift_bank.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fs_shift_bank_if.sv
// Bus bundle for fs_shift_bank: lock-step mode/data inputs and per-lane register outputs.
// The bank drives the slave side; the controller or test environment uses the master side.
interface fs_shift_bank_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 1
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]                MODE;
    logic [CHANNELS*WIDTH-1:0] P;
    logic [CHANNELS-1:0]       SD_UP;
    logic [CHANNELS-1:0]       SD_DN;
    logic                      ROT;
    logic [CHANNELS*WIDTH-1:0] Q;
    logic [CHANNELS-1:0]       SO_UP;
    logic [CHANNELS-1:0]       SO_DN;
    logic [CW-1:0]             CNT;
    logic                      DONE;

    modport master (
        output MODE, P, SD_UP, SD_DN, ROT,
        input  Q, SO_UP, SO_DN, CNT, DONE
    );

    modport slave (
        input  MODE, P, SD_UP, SD_DN, ROT,
        output Q, SO_UP, SO_DN, CNT, DONE
    );
endinterface

// File: rtl/fs_shift_bank.sv
// Multi-lane bidirectional shift register bank with parallel load, shared shift counter and
// word-done strobe, updating on the falling CK edge. Define FS_ROTATE_EN to enable rotate (ROT).
module fs_shift_bank #(
    parameter int               WIDTH    = 4,
    parameter int               CHANNELS = 1,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic              CK,
    input  logic              nRESET,
    fs_shift_bank_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CHANNELS*WIDTH-1:0] q_q, q_d;
    logic [CHANNELS*WIDTH-1:0] up_next, dn_next;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      done_q, done_d;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        logic [WIDTH-1:0] lane;
        logic             up_in;
        logic             dn_in;

        assign lane = q_q[n*WIDTH +: WIDTH];
`ifdef FS_ROTATE_EN
        assign up_in = bus.ROT ? lane[WIDTH-1] : bus.SD_UP[n];
        assign dn_in = bus.ROT ? lane[0]       : bus.SD_DN[n];
`else
        assign up_in = bus.SD_UP[n];
        assign dn_in = bus.SD_DN[n];
`endif
        assign up_next[n*WIDTH +: WIDTH] = {lane[WIDTH-2:0], up_in};
        assign dn_next[n*WIDTH +: WIDTH] = {dn_in, lane[WIDTH-1:1]};
        assign bus.SO_UP[n] = lane[WIDTH-1];
        assign bus.SO_DN[n] = lane[0];
    end

`ifndef FS_ROTATE_EN
    logic unused_rot;
    assign unused_rot = bus.ROT;
`endif

    // The counter is shared and direction-agnostic; a load restarts the word.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        case (bus.MODE)
            2'b01: begin
                q_d   = bus.P;
                cnt_d = '0;
            end
            2'b10, 2'b11: begin
                q_d = bus.MODE[0] ? dn_next : up_next;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    always_ff @(negedge CK or negedge nRESET) begin
        if (!nRESET) begin
            q_q    <= {CHANNELS{INIT}};
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.CNT  = cnt_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_fs_shift_bank.sv
// Directed bench for fs_shift_bank with WIDTH=4, CHANNELS=2; expectations follow FS_ROTATE_EN.
module tb_fs_shift_bank;
    logic CK;
    logic nRESET;
    int   total;
    int   bad;

    fs_shift_bank_if #(.WIDTH(4), .CHANNELS(2)) bus ();

    fs_shift_bank #(.WIDTH(4), .CHANNELS(2), .INIT(4'h0)) dut (
        .CK     (CK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    initial CK = 1'b1;
    always #5 CK = ~CK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic [1:0] mode, input logic [7:0] p,
                                  input logic [1:0] up, input logic [1:0] dn, input logic rot);
        @(posedge CK);
        bus.MODE  = mode;
        bus.P     = p;
        bus.SD_UP = up;
        bus.SD_DN = dn;
        bus.ROT   = rot;
        @(negedge CK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] q, input logic [2:0] cnt,
                               input logic done);
        check_output({tag, ".Q"}, 32'(bus.Q), 32'(q));
        check_output({tag, ".CNT"}, 32'(bus.CNT), 32'(cnt));
        check_output({tag, ".DONE"}, 32'(bus.DONE), 32'(done));
    endtask

    initial begin
        logic [7:0] rot_exp [4];
        total     = 0;
        bad       = 0;
        bus.MODE  = 2'b00;
        bus.P     = '0;
        bus.SD_UP = '0;
        bus.SD_DN = '0;
        bus.ROT   = 1'b0;
        nRESET    = 1'b1;

        // Asynchronous reset with no clock edge yet
        #1 nRESET = 1'b0;
        #1 check_state("reset", 8'h00, 3'd0, 1'b0);
        @(posedge CK);
        #1 nRESET = 1'b1;

        // Load then four shifts up; lane1 fills with ones
        apply_stimulus(2'b01, 8'h0A, 2'b00, 2'b00, 1'b0);
        check_state("load0A", 8'h0A, 3'd0, 1'b0);
        apply_stimulus(2'b10, 8'h00, 2'b10, 2'b00, 1'b0);
        check_state("up1", 8'h14, 3'd1, 1'b0);
        check_output("up1.SO_UP", 32'(bus.SO_UP), 32'h0);
        check_output("up1.SO_DN", 32'(bus.SO_DN), 32'h2);
        apply_stimulus(2'b10, 8'h00, 2'b11, 2'b00, 1'b0);
        check_state("up2", 8'h39, 3'd2, 1'b0);
        check_output("up2.SO_UP", 32'(bus.SO_UP), 32'h1);
        check_output("up2.SO_DN", 32'(bus.SO_DN), 32'h3);
        apply_stimulus(2'b10, 8'h00, 2'b10, 2'b00, 1'b0);
        check_state("up3", 8'h72, 3'd3, 1'b0);
        check_output("up3.SO_UP", 32'(bus.SO_UP), 32'h0);
        apply_stimulus(2'b10, 8'h00, 2'b11, 2'b00, 1'b0);
        check_state("up4", 8'hF5, 3'd0, 1'b1);
        check_output("up4.SO_UP", 32'(bus.SO_UP), 32'h2);
        check_output("up4.SO_DN", 32'(bus.SO_DN), 32'h3);
        apply_stimulus(2'b00, 8'hFF, 2'b11, 2'b11, 1'b0);
        check_state("hold", 8'hF5, 3'd0, 1'b0);

        // Two-lane shift down with independent serial inputs
        apply_stimulus(2'b01, 8'h3C, 2'b00, 2'b00, 1'b0);
        apply_stimulus(2'b11, 8'h00, 2'b00, 2'b10, 1'b0);
        check_state("dn", 8'h96, 3'd1, 1'b0);

        // Holds stretch the word; mixed directions share the count
        apply_stimulus(2'b01, 8'h00, 2'b00, 2'b00, 1'b0);
        apply_stimulus(2'b10, 8'h00, 2'b00, 2'b00, 1'b0);
        apply_stimulus(2'b11, 8'h00, 2'b00, 2'b00, 1'b0);
        apply_stimulus(2'b10, 8'h00, 2'b00, 2'b00, 1'b0);
        check_state("mix3", 8'h00, 3'd3, 1'b0);
        apply_stimulus(2'b00, 8'h00, 2'b00, 2'b00, 1'b0);
        apply_stimulus(2'b00, 8'h00, 2'b00, 2'b00, 1'b0);
        check_state("mixhold", 8'h00, 3'd3, 1'b0);
        apply_stimulus(2'b11, 8'h00, 2'b00, 2'b00, 1'b0);
        check_state("mix6", 8'h00, 3'd0, 1'b1);
        apply_stimulus(2'b10, 8'h00, 2'b00, 2'b00, 1'b0);
        apply_stimulus(2'b10, 8'h00, 2'b00, 2'b00, 1'b0);
        check_state("mid2", 8'h00, 3'd2, 1'b0);
        apply_stimulus(2'b01, 8'h5A, 2'b00, 2'b00, 1'b0);
        check_state("midload", 8'h5A, 3'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(2'b11, 8'h00, 2'b00, 2'b00, 1'b0);
            check_output($sformatf("after_load%0d.DONE", i), 32'(bus.DONE), 32'(i == 4));
            check_output($sformatf("after_load%0d.CNT", i), 32'(bus.CNT), 32'(i % 4));
        end

        // Rotate request: wraps with FS_ROTATE_EN, otherwise serial input (0) is used
`ifdef FS_ROTATE_EN
        rot_exp = '{8'h01, 8'h02, 8'h04, 8'h08};
`else
        rot_exp = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
        apply_stimulus(2'b01, 8'h08, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(2'b10, 8'h00, 2'b00, 2'b00, 1'b1);
            check_state($sformatf("rotup%0d", i + 1), rot_exp[i], 3'((i + 1) % 4), 1'(i == 3));
        end
        apply_stimulus(2'b01, 8'h01, 2'b00, 2'b00, 1'b0);
        apply_stimulus(2'b11, 8'h00, 2'b00, 2'b00, 1'b1);
`ifdef FS_ROTATE_EN
        check_state("rotdn", 8'h08, 3'd1, 1'b0);
`else
        check_state("rotdn", 8'h00, 3'd1, 1'b0);
`endif

        // Continuous shifting gives a single-cycle DONE every fourth shift
        apply_stimulus(2'b01, 8'h00, 2'b00, 2'b00, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            apply_stimulus(2'b10, 8'h00, 2'b01, 2'b00, 1'b0);
            check_output($sformatf("cont%0d.DONE", i), 32'(bus.DONE), 32'(i % 4 == 0));
        end
        check_output("cont.Q", 32'(bus.Q), 32'h0F);

        // Async reset while DONE is high, held across a clock edge
        @(posedge CK);
        #1 nRESET = 1'b0;
        #1 check_state("midreset", 8'h00, 3'd0, 1'b0);
        bus.MODE = 2'b01;
        bus.P    = 8'hC3;
        @(negedge CK);
        #1 check_state("heldreset", 8'h00, 3'd0, 1'b0);
        @(posedge CK);
        #1 nRESET = 1'b1;
        @(negedge CK);
        #1 check_state("postreset", 8'hC3, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
